dds_voice_scheduler: RTL and testbench
======================================

# dds_voice_scheduler

Time-multiplexes one shared note-step ROM and one shared sine ROM across `VOICES` polyphonic voices, giving the synth polyphony without replicating DDS datapaths. Holds per-voice note and phase state, allocates voices on note events, and on each sample tick sweeps all voices. The swept samples are mixed into one output word for the audio output stage.

## Interface
- `DATA_WDTH`, 24: signed sine sample width; also the mix width.
- `ADDR_WDTH`, 12: sine table address bits.
- `CNTR_WDTH`, 4: fractional phase bits; phase width is `ADDR_WDTH+CNTR_WDTH`.
- `VOICES`, 4: voice count; power of two, 2..16.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sample_tick`  in  1  one-cycle pulse per output sample (48 kHz).
- `note_on`  in  1  one-cycle pulse: start `note_in`.
- `note_off`  in  1  one-cycle pulse: release `note_in`.
- `note_in`  in  7  MIDI note number for `note_on` / `note_off`.
- `step_addr`  out  7  note-step ROM address.
- `step_data`  in  `ADDR_WDTH+CNTR_WDTH`  note-step ROM data; 1-cycle read latency.
- `sine_addr`  out  `ADDR_WDTH+CNTR_WDTH`  sine ROM phase address.
- `sine_data`  in  `DATA_WDTH`  signed sine ROM data; 1-cycle read latency.
- `mix`  out  `DATA_WDTH`  mixed signed sample; held between sweeps.
- `mix_valid`  out  1  one-cycle pulse when `mix` updates.
- `busy`  out  1  sweep in progress.
- `active_mask`  out  `VOICES`  bit v set while voice v is active.
- `voice_drop`  out  1  one-cycle pulse: `note_on` refused because no voice is free.
- `tick_miss`  out  1  one-cycle pulse: `sample_tick` arrived while busy.

## Operation
- Per-voice state: `active`, `note[6:0]`, `phase`. Reset clears all three to 0.
- `note_on`:
  - If an active voice already holds `note_in`, retrigger it: set its phase to 0.
  - Otherwise allocate the lowest-index free voice: active=1, note=`note_in`, phase=0.
  - If no voice is free, pulse `voice_drop` and change no state.
- `note_off`: clear `active` on the voice holding `note_in`. Phase is held. No-op if the note is not held.
- `note_on` and `note_off` in the same cycle: `note_off` wins and `note_on` is ignored.
- Note events are accepted at any time, including mid-sweep. Table writes are visible from the next cycle.
- FSM states: IDLE, STEP, SINE, ACC, DONE.
  - IDLE: on `sample_tick`, clear the accumulator, set v=0, go to STEP.
  - STEP: drive `step_addr`=note[v], go to SINE.
  - SINE: drive `sine_addr`=phase[v]. If active[v], set phase[v] += `step_data`, truncated to the phase width (phase wraps modulo 2^(`ADDR_WDTH+CNTR_WDTH`)). Go to ACC.
  - ACC: if active[v], add sign-extended `sine_data` to the accumulator. If v=`VOICES`-1 go to DONE, else increment v and go to STEP.
  - DONE: register `mix`, pulse `mix_valid`, go to IDLE.
- Inactive voices are still swept, but contribute 0 and their phase does not advance.
- Accumulator width is `DATA_WDTH`+log2(`VOICES`).
- Reset asserted mid-sweep: FSM returns to IDLE, the sweep is aborted, and no `mix_valid` is issued.

## Timing
- Reset values: `mix`=0, `mix_valid`=0, `busy`=0, `active_mask`=0, `voice_drop`=0, `tick_miss`=0, `step_addr`=0, `sine_addr`=0.
- Tick sampled in IDLE at cycle T:
  - STEP for voice v occurs at T+1+3v.
  - `mix_valid` is high in cycle T+3·`VOICES`+1, with `mix` valid from that cycle onward.
- `busy` is high from T+1 through T+3·`VOICES`+1.
- `sample_tick` while `busy`=1: the tick is dropped and `tick_miss` pulses the following cycle.
- `voice_drop` pulses in the cycle after the refused `note_on`.
- `active_mask` reflects a note event one cycle after the event.

## Configuration
- `VOICE_SAT_EN` undefined: `mix` = accumulator arithmetically shifted right by log2(`VOICES`). This cannot overflow.
- `VOICE_SAT_EN` defined: no shift. `mix` = accumulator saturated to the signed `DATA_WDTH` range, i.e. [-2^(`DATA_WDTH`-1), 2^(`DATA_WDTH`-1)-1].

## Test plan
- Reset, no notes, `VOICES`=4, tick at T -> `mix_valid` at T+13, `mix`=0, `busy` high T+1..T+13, all phases remain 0.
- `note_on` 69; step model returns 0x0100; sine model returns 0x100000; 4 ticks -> `mix`=0x040000 (no SAT). Voice 0 `sine_addr` on the 4th tick = 0x0300.
- 5 distinct `note_on` with `VOICES`=4 -> `active_mask`=4'hF, `voice_drop` pulses on the 5th note, voice states unchanged.
- `note_off` 69 (voice 0), then `note_on` 72 -> bit 0 clears, then voice 0 is reallocated with note 72 and phase 0.
- `sample_tick` at T+5 during a sweep -> `tick_miss` pulse at T+6, only one `mix_valid` (at T+13); reset at T+7 -> `busy`=0 immediately, no `mix_valid`.
- `VOICES`=2, both voices active, sine model returns 0x600000:
  - `VOICE_SAT_EN` defined -> `mix`=0x7FFFFF.
  - `VOICE_SAT_EN` undefined -> `mix`=0x600000 (0xC00000 >>> 1).

Source files
------------

// File: rtl/dds_voice_scheduler.sv
// rtl/dds_voice_scheduler.sv - time-multiplexed DDS voice scheduler and mixer
//
// Purpose:
//   Holds per-voice note/phase state for VOICES voices, allocates voices on
//   note events, and on each sample_tick sweeps every voice through one shared
//   note-step ROM and one shared sine ROM (both 1-cycle read latency), summing
//   the active voices into one mixed sample.
//
// Configuration macro:
//   VOICE_SAT_EN - defined: mix is the accumulator saturated to DATA_WDTH.
//                  undefined: mix is the accumulator >>> log2(VOICES).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   sample_tick         start a sweep (dropped while busy)
//   note_on, note_off   note events for note_in (note_off wins on collision)
//   note_in             MIDI note number
//   step_addr/step_data note-step ROM port
//   sine_addr/sine_data sine ROM port (phase address, signed sample)
//   mix, mix_valid      mixed sample and its one-cycle update strobe
//   busy                sweep in progress
//   active_mask         per-voice active flags
//   voice_drop          note_on refused, no free voice
//   tick_miss           sample_tick arrived while busy
module dds_voice_scheduler #(
  parameter int DATA_WDTH = 24,
  parameter int ADDR_WDTH = 12,
  parameter int CNTR_WDTH = 4,
  parameter int VOICES    = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sample_tick,
  input  logic                           note_on,
  input  logic                           note_off,
  input  logic [6:0]                     note_in,
  output logic [6:0]                     step_addr,
  input  logic [ADDR_WDTH+CNTR_WDTH-1:0] step_data,
  output logic [ADDR_WDTH+CNTR_WDTH-1:0] sine_addr,
  input  logic [DATA_WDTH-1:0]           sine_data,
  output logic [DATA_WDTH-1:0]           mix,
  output logic                           mix_valid,
  output logic                           busy,
  output logic [VOICES-1:0]              active_mask,
  output logic                           voice_drop,
  output logic                           tick_miss
);

  localparam int PH_WDTH   = ADDR_WDTH + CNTR_WDTH;
  localparam int VIDX_WDTH = $clog2(VOICES);
  localparam int ACC_WDTH  = DATA_WDTH + VIDX_WDTH;

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_SINE, S_ACC, S_DONE} state_t;

  state_t                       state;
  logic [VOICES-1:0]            active;
  logic [6:0]                   note  [VOICES];
  logic [PH_WDTH-1:0]           phase [VOICES];
  logic [VIDX_WDTH-1:0]         vidx;
  logic [VIDX_WDTH-1:0]         vidx_nxt;
  logic signed [ACC_WDTH-1:0]   acc;
  logic signed [ACC_WDTH-1:0]   sample_ext;
  logic signed [ACC_WDTH-1:0]   acc_next;
  logic [DATA_WDTH-1:0]         mix_next;

  // Voice lookup; descending scan so the lowest matching index wins.
  logic                 hit_found;
  logic                 free_found;
  logic [VIDX_WDTH-1:0] hit_idx;
  logic [VIDX_WDTH-1:0] free_idx;

  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (active[i] && (note[i] == note_in)) begin
        hit_found = 1'b1;
        hit_idx   = VIDX_WDTH'(i);
      end
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = VIDX_WDTH'(i);
      end
    end
  end

  assign vidx_nxt   = vidx + 1'b1;
  // Inactive voices are swept but contribute nothing.
  assign sample_ext = active[vidx] ? {{VIDX_WDTH{sine_data[DATA_WDTH-1]}}, sine_data} : '0;
  assign acc_next   = acc + sample_ext;

`ifdef VOICE_SAT_EN
  logic signed [ACC_WDTH-1:0] sat_max;
  logic signed [ACC_WDTH-1:0] sat_min;
  assign sat_max = {{(VIDX_WDTH+1){1'b0}}, {(DATA_WDTH-1){1'b1}}};
  assign sat_min = {{(VIDX_WDTH+1){1'b1}}, {(DATA_WDTH-1){1'b0}}};
  always_comb begin
    if (acc_next > sat_max)      mix_next = {1'b0, {(DATA_WDTH-1){1'b1}}};
    else if (acc_next < sat_min) mix_next = {1'b1, {(DATA_WDTH-1){1'b0}}};
    else                         mix_next = acc_next[DATA_WDTH-1:0];
  end
`else
  // Dividing by the voice count keeps the full-scale sum in range.
  logic signed [ACC_WDTH-1:0] acc_shr;
  assign acc_shr  = acc_next >>> VIDX_WDTH;
  assign mix_next = acc_shr[DATA_WDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      active     <= '0;
      vidx       <= '0;
      acc        <= '0;
      mix        <= '0;
      mix_valid  <= 1'b0;
      busy       <= 1'b0;
      voice_drop <= 1'b0;
      tick_miss  <= 1'b0;
      step_addr  <= '0;
      sine_addr  <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note[i]  <= '0;
        phase[i] <= '0;
      end
    end else begin
      mix_valid  <= 1'b0;
      voice_drop <= 1'b0;
      tick_miss  <= sample_tick && busy;

      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            acc       <= '0;
            vidx      <= '0;
            step_addr <= note[0];
            busy      <= 1'b1;
            state     <= S_STEP;
          end
        end
        S_STEP: begin
          sine_addr <= phase[vidx];
          state     <= S_SINE;
        end
        S_SINE: begin
          // step_data for this voice arrives now (address issued in STEP).
          if (active[vidx]) phase[vidx] <= phase[vidx] + step_data;
          state <= S_ACC;
        end
        S_ACC: begin
          acc <= acc_next;
          if (vidx == VIDX_WDTH'(VOICES - 1)) begin
            // Register the result on entry to DONE so mix_valid is high in DONE.
            mix       <= mix_next;
            mix_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            vidx      <= vidx_nxt;
            step_addr <= note[vidx_nxt];
            state     <= S_STEP;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Note events come last so a retrigger/allocation beats a concurrent
      // sweep phase update on the same voice.
      if (note_off) begin
        if (hit_found) active[hit_idx] <= 1'b0;
      end else if (note_on) begin
        if (hit_found) begin
          phase[hit_idx] <= '0;
        end else if (free_found) begin
          active[free_idx] <= 1'b1;
          note[free_idx]   <= note_in;
          phase[free_idx]  <= '0;
        end else begin
          voice_drop <= 1'b1;
        end
      end
    end
  end

  assign active_mask = active;

endmodule

// File: tb/tb_dds_voice_scheduler.sv
// tb/tb_dds_voice_scheduler.sv - directed self-checking bench for dds_voice_scheduler
module tb_dds_voice_scheduler;

  logic        clk;
  logic        rst_n;

  logic        tick4, on4, off4;
  logic [6:0]  note4;
  logic [6:0]  step_addr4;
  logic [15:0] step_data4;
  logic [15:0] sine_addr4;
  logic [23:0] sine_data4;
  logic [23:0] mix4;
  logic        mix_valid4, busy4, drop4, miss4;
  logic [3:0]  mask4;
  logic [23:0] sine_val4;

  logic        tick2, on2, off2;
  logic [6:0]  note2;
  logic [6:0]  step_addr2;
  logic [15:0] step_data2;
  logic [15:0] sine_addr2;
  logic [23:0] sine_data2;
  logic [23:0] mix2;
  logic        mix_valid2, busy2, drop2, miss2;
  logic [1:0]  mask2;
  logic [23:0] sine_val2;

  int checks;
  int errors;

`ifdef VOICE_SAT_EN
  localparam logic [23:0] M1 = 24'h100000;
  localparam logic [23:0] M3 = 24'h300000;
  localparam logic [23:0] M4 = 24'h400000;
  localparam logic [23:0] M2 = 24'h7FFFFF;
`else
  localparam logic [23:0] M1 = 24'h040000;
  localparam logic [23:0] M3 = 24'h0C0000;
  localparam logic [23:0] M4 = 24'h100000;
  localparam logic [23:0] M2 = 24'h600000;
`endif

  dds_voice_scheduler #(.VOICES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sample_tick(tick4), .note_on(on4), .note_off(off4),
    .note_in(note4), .step_addr(step_addr4), .step_data(step_data4),
    .sine_addr(sine_addr4), .sine_data(sine_data4), .mix(mix4), .mix_valid(mix_valid4),
    .busy(busy4), .active_mask(mask4), .voice_drop(drop4), .tick_miss(miss4)
  );

  dds_voice_scheduler #(.VOICES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sample_tick(tick2), .note_on(on2), .note_off(off2),
    .note_in(note2), .step_addr(step_addr2), .step_data(step_data2),
    .sine_addr(sine_addr2), .sine_data(sine_data2), .mix(mix2), .mix_valid(mix_valid2),
    .busy(busy2), .active_mask(mask2), .voice_drop(drop2), .tick_miss(miss2)
  );

  always #5 clk = ~clk;

  // ROM models with one cycle of read latency.
  always @(posedge clk) begin
    step_data4 <= 16'h0100;
    sine_data4 <= sine_val4;
    step_data2 <= 16'h0100;
    sine_data2 <= sine_val2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic note4_ev(input logic on, input logic off, input logic [6:0] n);
    on4 = on; off4 = off; note4 = n;
    @(negedge clk);
    on4 = 1'b0; off4 = 1'b0;
  endtask

  task automatic sweep4(input string tag, input logic [23:0] exp_mix,
                        input logic [6:0] exp_step0, input logic [15:0] exp_sine0);
    int nvalid;
    nvalid = 0;
    tick4 = 1'b1;
    @(negedge clk);
    tick4 = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1) check({tag, " step_addr v0"}, step_addr4, exp_step0);
      if (k == 2) check({tag, " sine_addr v0"}, sine_addr4, exp_sine0);
      if (k == 1 || k == 13) check({tag, " busy high"}, busy4, 1);
      if (k == 14) check({tag, " busy low"}, busy4, 0);
      if (mix_valid4) begin
        nvalid++;
        check({tag, " mix_valid cycle"}, k, 13);
      end
    end
    check({tag, " mix_valid count"}, nvalid, 1);
    check({tag, " mix"}, mix4, exp_mix);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nvalid;
    clk = 1'b0; rst_n = 1'b0;
    tick4 = 0; on4 = 0; off4 = 0; note4 = '0;
    tick2 = 0; on2 = 0; off2 = 0; note2 = '0;
    sine_val4 = 24'h100000;
    sine_val2 = 24'h600000;
    checks = 0; errors = 0;

    repeat (3) @(negedge clk);
    check("rst mix", mix4, 0);
    check("rst mix_valid", mix_valid4, 0);
    check("rst busy", busy4, 0);
    check("rst active_mask", mask4, 0);
    check("rst voice_drop", drop4, 0);
    check("rst tick_miss", miss4, 0);
    check("rst step_addr", step_addr4, 0);
    check("rst sine_addr", sine_addr4, 0);
    rst_n = 1'b1;
    @(negedge clk);

    sweep4("idle1", 24'h0, 7'd0, 16'h0);
    sweep4("idle2", 24'h0, 7'd0, 16'h0);

    note4_ev(1, 0, 7'd69);
    check("on69 mask", mask4, 4'h1);
    check("on69 drop", drop4, 0);
    sweep4("n69 s1", M1, 7'd69, 16'h0000);
    sweep4("n69 s2", M1, 7'd69, 16'h0100);
    sweep4("n69 s3", M1, 7'd69, 16'h0200);
    sweep4("n69 s4", M1, 7'd69, 16'h0300);

    note4_ev(1, 0, 7'd60); check("on60 mask", mask4, 4'h3);
    note4_ev(1, 0, 7'd62); check("on62 mask", mask4, 4'h7);
    note4_ev(1, 0, 7'd64); check("on64 mask", mask4, 4'hF);
    note4_ev(1, 0, 7'd65);
    check("on65 drop pulse", drop4, 1);
    check("on65 mask", mask4, 4'hF);
    @(negedge clk);
    check("on65 drop end", drop4, 0);
    sweep4("full", M4, 7'd69, 16'h0400);

    note4_ev(1, 0, 7'd69);
    check("retrig drop", drop4, 0);
    check("retrig mask", mask4, 4'hF);
    sweep4("retrig", M4, 7'd69, 16'h0000);

    note4_ev(0, 1, 7'd69); check("off69 mask", mask4, 4'hE);
    note4_ev(1, 0, 7'd72); check("on72 mask", mask4, 4'hF);
    sweep4("realloc", M4, 7'd72, 16'h0000);

    note4_ev(1, 1, 7'd60); check("on+off mask", mask4, 4'hD);
    check("on+off drop", drop4, 0);
    note4_ev(0, 1, 7'd100); check("off unheld mask", mask4, 4'hD);

    // Extra tick mid-sweep is dropped and flagged.
    nvalid = 0;
    tick4 = 1'b1;
    @(negedge clk);
    tick4 = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 6) begin
        check("miss pulse", miss4, 1);
        tick4 = 1'b0;
      end
      if (k == 7) check("miss end", miss4, 0);
      if (mix_valid4) begin
        nvalid++;
        check("miss mix_valid cycle", k, 13);
      end
      if (k == 5) tick4 = 1'b1;
    end
    check("miss mix_valid count", nvalid, 1);
    check("miss mix", mix4, M3);

    // Reset in the middle of a sweep.
    nvalid = 0;
    tick4 = 1'b1;
    @(negedge clk);
    tick4 = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy", busy4, 0);
    check("abort mask", mask4, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (mix_valid4) nvalid++;
    end
    check("abort mix_valid count", nvalid, 0);
    check("abort busy after", busy4, 0);

    // Two-voice instance, both voices at 0x600000.
    on2 = 1'b1; note2 = 7'd10;
    @(negedge clk);
    note2 = 7'd20;
    @(negedge clk);
    on2 = 1'b0;
    check("v2 mask", mask2, 2'h3);
    nvalid = 0;
    tick2 = 1'b1;
    @(negedge clk);
    tick2 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      if (mix_valid2) begin
        nvalid++;
        check("v2 mix_valid cycle", k, 7);
      end
    end
    check("v2 mix_valid count", nvalid, 1);
    check("v2 mix", mix2, M2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
